// File: rtl/ped_crossing_pkg.sv
// Shared types and helpers for the pedestrian-crossing controller:
// state encoding, lamp bundle and the per-state lamp decode.
package ped_crossing_pkg;

    typedef enum logic [2:0] {
        CAR_GREEN  = 3'd0,
        CAR_YELLOW = 3'd1,
        ALLRED_1   = 3'd2,
        PED_WALK   = 3'd3,
        PED_CLEAR  = 3'd4,
        ALLRED_2   = 3'd5,
        FLASH      = 3'd6
    } state_t;

    localparam logic LAMP_ON  = 1'b1;
    localparam logic LAMP_OFF = 1'b0;

    typedef struct packed {
        logic car_red;
        logic car_yellow;
        logic car_green;
        logic ped_red;
        logic ped_green;
    } lamps_t;

    // Divider width; a divide-by-2 still needs one bit.
    function automatic int unsigned tick_w(input int unsigned div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

    // Logical lamp values for a state; blink drives the flashing lamp.
    function automatic lamps_t lamps_for(input state_t st, input logic blink);
        lamps_t l;
        l = '{default: LAMP_OFF};
        case (st)
            CAR_GREEN: begin
                l.car_green = LAMP_ON;
                l.ped_red   = LAMP_ON;
            end
            CAR_YELLOW: begin
                l.car_yellow = LAMP_ON;
                l.ped_red    = LAMP_ON;
            end
            PED_WALK: begin
                l.car_red   = LAMP_ON;
                l.ped_green = LAMP_ON;
            end
            PED_CLEAR: begin
                l.car_red   = LAMP_ON;
                l.ped_green = blink;
            end
            FLASH: begin
                l.car_yellow = blink;
            end
            default: begin
                l.car_red = LAMP_ON;
                l.ped_red = LAMP_ON;
            end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/ped_crossing_ctrl_tick_gen.sv
// Free-running clk divider producing a registered one-cycle tick every
// TICK_DIV cycles; the pulse is timed to coincide with the last divider count.
module tick_gen
    import ped_crossing_pkg::*;
#(
    parameter int unsigned TICK_DIV = 12000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned       TICK_W   = tick_w(TICK_DIV);
    localparam logic [TICK_W-1:0] DIV_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] DIV_PRE  = TICK_W'(TICK_DIV - 2);

    logic [TICK_W-1:0] div;

    // tick is registered one count early so it is high while div == DIV_LAST
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div  <= '0;
            tick <= 1'b0;
        end else begin
            div  <= (div == DIV_LAST) ? '0 : div + TICK_W'(1);
            tick <= (div == DIV_PRE);
        end
    end

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian-crossing controller: input synchronizers, request latch,
// phase FSM with tick-based timing and registered LED pins.
module ped_crossing_ctrl
    import ped_crossing_pkg::*;
#(
    parameter int unsigned TICK_DIV       = 12000000,
    parameter int unsigned CNT_W          = 6,
    parameter int unsigned MIN_GREEN      = 15,
    parameter int unsigned YELLOW_T       = 3,
    parameter int unsigned ALLRED_T       = 1,
    parameter int unsigned WALK_T         = 5,
    parameter int unsigned CLEAR_T        = 4,
    parameter int unsigned LED_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_n,
    input  logic       flash_mode,
    output logic       car_red,
    output logic       car_yellow,
    output logic       car_green,
    output logic       ped_red,
    output logic       ped_green,
    output logic       req_pending,
    output logic [2:0] phase,
    output logic       tick
);

    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_T - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST  = CNT_W'(CLEAR_T - 1);

    localparam logic [4:0] POL_MASK = (LED_ACTIVE_LOW != 0) ? 5'b11111 : 5'b00000;
    localparam lamps_t     PINS_RST = lamps_t'(lamps_for(CAR_GREEN, LAMP_ON) ^ POL_MASK);

    logic [1:0]       req_sync;
    logic [1:0]       flash_sync;
    logic             req_seen;
    logic             flash_seen;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             blink, blink_n;
    logic             req_next;
    lamps_t           pins, pins_next;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Two-stage synchronizers; the button is carried as logical "pressed".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_sync   <= 2'b00;
            flash_sync <= 2'b00;
        end else begin
            req_sync   <= {req_sync[0], ~req_n};
            flash_sync <= {flash_sync[0], flash_mode};
        end
    end

    assign req_seen   = req_sync[1];
    assign flash_seen = flash_sync[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= CAR_GREEN;
            cnt         <= '0;
            blink       <= LAMP_ON;
            req_pending <= 1'b0;
            pins        <= PINS_RST;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            blink       <= blink_n;
            req_pending <= req_next;
            pins        <= pins_next;
        end
    end

    // Next state, phase counter, blink phase, request latch and lamp pins.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        blink_n   = blink;
        req_next  = req_pending;
        pins_next = pins;

        if (tick) begin
            blink_n = ~blink;
            if (flash_seen) begin
                state_n = FLASH;
            end else begin
                case (state)
                    CAR_GREEN: begin
                        // Counter parks at GREEN_LAST until a request arrives.
                        if (cnt >= GREEN_LAST) begin
                            if (req_pending) state_n = CAR_YELLOW;
                        end else begin
                            cnt_n = cnt + CNT_W'(1);
                        end
                    end
                    CAR_YELLOW: begin
                        if (cnt == YELLOW_LAST) state_n = ALLRED_1;
                        else                    cnt_n   = cnt + CNT_W'(1);
                    end
                    ALLRED_1: begin
                        if (cnt == ALLRED_LAST) state_n = PED_WALK;
                        else                    cnt_n   = cnt + CNT_W'(1);
                    end
                    PED_WALK: begin
                        if (cnt == WALK_LAST) state_n = PED_CLEAR;
                        else                  cnt_n   = cnt + CNT_W'(1);
                    end
                    PED_CLEAR: begin
                        if (cnt == CLEAR_LAST) state_n = ALLRED_2;
                        else                   cnt_n   = cnt + CNT_W'(1);
                    end
                    ALLRED_2: begin
                        if (cnt == ALLRED_LAST) state_n = CAR_GREEN;
                        else                    cnt_n   = cnt + CNT_W'(1);
                    end
                    FLASH: begin
                        state_n = ALLRED_2;
                    end
                    default: begin
                        state_n = CAR_GREEN;
                    end
                endcase
            end
        end

        if (state_n != state) begin
            cnt_n   = '0;
            blink_n = LAMP_ON;
        end

        // Clearing on walk entry or around flash wins over a fresh press.
        if (req_seen && (state != PED_WALK)) req_next = 1'b1;
        if ((state == FLASH) || (state_n == FLASH) ||
            ((state_n == PED_WALK) && (state != PED_WALK))) begin
            req_next = 1'b0;
        end

        pins_next = lamps_t'(lamps_for(state_n, blink_n) ^ POL_MASK);
    end

    assign car_red    = pins.car_red;
    assign car_yellow = pins.car_yellow;
    assign car_green  = pins.car_green;
    assign ped_red    = pins.ped_red;
    assign ped_green  = pins.ped_green;
    assign phase      = state;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl with TICK_DIV=4 and default durations;
// expected phases and pin patterns are hand-derived tick by tick.
module tb_ped_crossing_ctrl;

    // Pin patterns {car_red, car_yellow, car_green, ped_red, ped_green}, active-low.
    localparam logic [4:0] P_GREEN      = 5'b11001;
    localparam logic [4:0] P_YELLOW     = 5'b10101;
    localparam logic [4:0] P_ALLRED     = 5'b01101;
    localparam logic [4:0] P_WALK       = 5'b01110;
    localparam logic [4:0] P_CLEAR_LIT  = 5'b01110;
    localparam logic [4:0] P_CLEAR_DARK = 5'b01111;
    localparam logic [4:0] P_FLASH_LIT  = 5'b10111;
    localparam logic [4:0] P_FLASH_DARK = 5'b11111;

    logic       clk;
    logic       rst;
    logic       req_n;
    logic       flash_mode;
    logic       car_red, car_yellow, car_green, ped_red, ped_green;
    logic       req_pending;
    logic [2:0] phase;
    logic       tick;

    int tests_run;
    int tests_failed;
    int tick_count;

    ped_crossing_ctrl #(
        .TICK_DIV (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_n       (req_n),
        .flash_mode  (flash_mode),
        .car_red     (car_red),
        .car_yellow  (car_yellow),
        .car_green   (car_green),
        .ped_red     (ped_red),
        .ped_green   (ped_green),
        .req_pending (req_pending),
        .phase       (phase),
        .tick        (tick)
    );

    always #5 clk = ~clk;

    // Ticks since reset; bumps on the edge where the FSM acts on the tick.
    always @(posedge clk or negedge rst) begin
        if (!rst)      tick_count <= 0;
        else if (tick) tick_count <= tick_count + 1;
    end

    function automatic logic [4:0] pins();
        return {car_red, car_yellow, car_green, ped_red, ped_green};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        req_n      = 1'b1;
        flash_mode = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_to_tick(input int n);
        int guard;
        guard = 0;
        while (tick_count < n && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (tick_count < n) check("tick_timeout", 32'(tick_count), 32'(n));
    endtask

    task automatic press(input int cycles);
        req_n = 1'b0;
        repeat (cycles) @(negedge clk);
        req_n = 1'b1;
    endtask

    task automatic cycles_to_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 20);
    endtask

    initial begin
        int n;
        int bad;
        int seen;

        clk          = 1'b0;
        tests_run    = 0;
        tests_failed = 0;

        // Reset values and idle behaviour.
        rst        = 1'b0;
        req_n      = 1'b1;
        flash_mode = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_pins", 32'(pins()), 32'(P_GREEN));
        check("rst_req", 32'(req_pending), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        rst = 1'b1;
        cycles_to_tick(n);
        check("first_tick_cycle", 32'(n), 32'd3);
        cycles_to_tick(n);
        check("tick_period", 32'(n), 32'd4);
        bad  = 0;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tick) seen++;
            if (phase != 3'd0 || pins() != P_GREEN || req_pending) bad++;
        end
        check("idle_bad_samples", 32'(bad), 32'd0);
        check("idle_tick_count", 32'(seen), 32'd50);

        // Early request, full cycle timing, press during walk ignored.
        do_reset();
        run_to_tick(3);
        req_n = 1'b0;
        repeat (2) @(negedge clk);
        check("req_latch_2clk", 32'(req_pending), 32'd0);
        @(negedge clk);
        check("req_latch_3clk", 32'(req_pending), 32'd1);
        req_n = 1'b1;
        run_to_tick(14);
        check("green_t14", 32'(phase), 32'd0);
        run_to_tick(15);
        check("yellow_t15", 32'(phase), 32'd1);
        check("yellow_pins", 32'(pins()), 32'(P_YELLOW));
        run_to_tick(17);
        check("yellow_t17", 32'(phase), 32'd1);
        run_to_tick(18);
        check("allred1_t18", 32'(phase), 32'd2);
        check("allred1_pins", 32'(pins()), 32'(P_ALLRED));
        check("req_before_walk", 32'(req_pending), 32'd1);
        run_to_tick(19);
        check("walk_t19", 32'(phase), 32'd3);
        check("walk_pins", 32'(pins()), 32'(P_WALK));
        check("req_clr_walk", 32'(req_pending), 32'd0);
        run_to_tick(20);
        press(3);
        run_to_tick(23);
        check("walk_t23", 32'(phase), 32'd3);
        check("walk_press_ignored", 32'(req_pending), 32'd0);
        run_to_tick(24);
        check("clear_t24", 32'(phase), 32'd4);
        check("clear_pins_t24", 32'(pins()), 32'(P_CLEAR_LIT));
        run_to_tick(25);
        check("clear_pins_t25", 32'(pins()), 32'(P_CLEAR_DARK));
        run_to_tick(26);
        check("clear_pins_t26", 32'(pins()), 32'(P_CLEAR_LIT));
        run_to_tick(27);
        check("clear_pins_t27", 32'(pins()), 32'(P_CLEAR_DARK));
        run_to_tick(28);
        check("allred2_t28", 32'(phase), 32'd5);
        check("allred2_pins", 32'(pins()), 32'(P_ALLRED));
        run_to_tick(29);
        check("green_t29", 32'(phase), 32'd0);
        check("green_pins_t29", 32'(pins()), 32'(P_GREEN));
        run_to_tick(70);
        check("green_hold_t70", 32'(phase), 32'd0);
        check("green_hold_req", 32'(req_pending), 32'd0);

        // Press during clear is served after a fresh minimum green.
        do_reset();
        run_to_tick(1);
        press(3);
        run_to_tick(25);
        press(2);
        run_to_tick(26);
        check("clear_press_latched", 32'(req_pending), 32'd1);
        check("clear_t26", 32'(phase), 32'd4);
        run_to_tick(29);
        check("green2_t29", 32'(phase), 32'd0);
        run_to_tick(43);
        check("green2_t43", 32'(phase), 32'd0);
        check("green2_req_t43", 32'(req_pending), 32'd1);
        run_to_tick(44);
        check("yellow2_t44", 32'(phase), 32'd1);

        // Flash mode entered mid-walk, then released.
        do_reset();
        run_to_tick(1);
        press(3);
        run_to_tick(21);
        check("walk_t21", 32'(phase), 32'd3);
        flash_mode = 1'b1;
        run_to_tick(22);
        check("flash_t22", 32'(phase), 32'd6);
        check("flash_pins_t22", 32'(pins()), 32'(P_FLASH_LIT));
        press(3);
        run_to_tick(23);
        check("flash_pins_t23", 32'(pins()), 32'(P_FLASH_DARK));
        check("flash_req_held", 32'(req_pending), 32'd0);
        run_to_tick(24);
        check("flash_pins_t24", 32'(pins()), 32'(P_FLASH_LIT));
        flash_mode = 1'b0;
        run_to_tick(25);
        check("flash_exit_t25", 32'(phase), 32'd5);
        check("flash_exit_pins", 32'(pins()), 32'(P_ALLRED));
        run_to_tick(26);
        check("flash_green_t26", 32'(phase), 32'd0);

        // Asynchronous reset in the middle of yellow.
        do_reset();
        run_to_tick(1);
        press(3);
        run_to_tick(16);
        check("pre_rst_yellow", 32'(phase), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_phase", 32'(phase), 32'd0);
        check("async_rst_pins", 32'(pins()), 32'(P_GREEN));
        check("async_rst_req", 32'(req_pending), 32'd0);
        check("async_rst_tick", 32'(tick), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cycles_to_tick(n);
        check("rst_tick_restart", 32'(n), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ped_crossing_ctrl.md
# ped_crossing_ctrl

Parametrised pedestrian-crossing traffic-light controller with a latched push-button request, minimum car-green time, all-red interlock and a flashing-yellow night mode. The design runs entirely in the `clk` domain: an internal tick-enable replaces any derived clock. It drives one car signal head and one pedestrian head directly to board LEDs, with selectable polarity.

## Interface
- `TICK_DIV`, 12000000: clk cycles per tick (1 s at 12 MHz); ≥2.
- `CNT_W`, 6: phase counter width; every duration must be ≥1 and ≤ 2^CNT_W−1.
- `MIN_GREEN`, 15: minimum car-green ticks before a request is served.
- `YELLOW_T`, 3: car-yellow ticks.
- `ALLRED_T`, 1: all-red ticks, applied on both sides of the walk.
- `WALK_T`, 5: steady pedestrian-green ticks.
- `CLEAR_T`, 4: blinking pedestrian-green ticks.
- `LED_ACTIVE_LOW`, 1: 1 means an LED pin is driven 0 to light it.

Ports:
- `clk` input 1: clock.
- `rst` input 1: asynchronous, active-low reset.
- `req_n` input 1: pedestrian button, active-low, asynchronous to clk.
- `flash_mode` input 1: night-mode request, asynchronous to clk.
- `car_red`, `car_yellow`, `car_green` output 1 each: car LEDs, polarity set by `LED_ACTIVE_LOW`.
- `ped_red`, `ped_green` output 1 each: pedestrian LEDs, polarity set by `LED_ACTIVE_LOW`.
- `req_pending` output 1: request latched and not yet served. Active-high.
- `phase` output 3: current state encoding.
- `tick` output 1: one-cycle tick pulse. Active-high.

## Operation
- `req_n` and `flash_mode` each pass through a 2-FF synchronizer.
- The request latch is set by a synchronized `req_n`=0 in any state except PED_WALK. It is cleared on entry to PED_WALK.
- The phase counter `cnt` counts ticks inside a state. It resets to 0 on every transition.
- The "done" condition is `tick` && `cnt`==DUR−1.
- States and transitions:
  - CAR_GREEN (0). Leaves on `tick` && `cnt`≥MIN_GREEN−1 && req latched, going to CAR_YELLOW. `cnt` saturates at MIN_GREEN−1 while waiting.
  - CAR_YELLOW (1). Done(YELLOW_T) → ALLRED_1.
  - ALLRED_1 (2). Done(ALLRED_T) → PED_WALK.
  - PED_WALK (3). Done(WALK_T) → PED_CLEAR.
  - PED_CLEAR (4). Done(CLEAR_T) → ALLRED_2.
  - ALLRED_2 (5). Done(ALLRED_T) → CAR_GREEN.
  - FLASH (6). Exits when synchronized `flash_mode`=0 at a tick, going to ALLRED_2 with `cnt`=0.
- A synchronized `flash_mode`=1 at any tick forces FLASH from any state. This has priority over the done condition. The request latch is cleared on FLASH entry and stays held clear during FLASH.
- Logical lamp values per state:
  - CAR_GREEN: car green, ped red.
  - CAR_YELLOW: car yellow, ped red.
  - ALLRED_1 and ALLRED_2: car red, ped red.
  - PED_WALK: car red, ped green.
  - PED_CLEAR: car red. Ped green toggles every tick, starting lit on entry; ped red stays off.
  - FLASH: car yellow toggles every tick, starting lit; all other lamps off.
- Physical pin = logical value XOR `LED_ACTIVE_LOW`.
- Reset values:
  - State CAR_GREEN, `cnt`=0, divider=0, latch=0, synchronizers=0 logical.
  - `req_pending`=0, `tick`=0, `phase`=0.
  - Lamps: car green and ped red lit, others dark. With default polarity the pins are `car_green`=0, `ped_red`=0, all other lamp pins 1.

## Timing
- The divider counts 0..TICK_DIV−1. `tick`=1 in the cycle the divider equals TICK_DIV−1, then the divider wraps to 0. The first tick is at clk cycle TICK_DIV after reset release.
- `req_pending` rises 3 clk cycles after `req_n` is sampled low (2 sync stages + latch). Button release does not clear it.
- State, `cnt`, `phase` and lamp outputs all update in the clk cycle following the tick. All outputs are registered; there are no combinational paths from inputs.
- A request arriving in the same cycle as PED_WALK entry is dropped, because the clear wins. A request arriving in PED_CLEAR or ALLRED_2 is latched and served after the next MIN_GREEN.
- Reset asserted mid-phase returns all state immediately and asynchronously; the tick divider restarts from 0.

## Structure
- `ped_crossing_pkg` holds:
  - the state enum with encodings 0..6;
  - the `LAMP_ON`/`LAMP_OFF` helper constants;
  - the `TICK_W` = $clog2(TICK_DIV) function.
- Sub-module `tick_gen` (parameter `TICK_DIV`) contains the free-running divider and produces the `tick` pulse. The top level holds the synchronizers, request latch, FSM and output register.

## Test plan
All scenarios use `TICK_DIV`=4 and default durations.
- **Reset:** hold `rst`=0, release, run 200 clk with no request. Expect `phase`=0, `car_green`=0, `ped_red`=0, all other lamp pins 1, `tick` every 4 clk.
- **Early request:** press `req_n` at tick 3. Expect `req_pending` 3 clk later, CAR_YELLOW after tick 15, then PED_WALK 4 ticks after that. `req_pending` drops on PED_WALK entry.
- **Full cycle timing:** verify yellow=3, all-red=1, walk=5 and clear=4 ticks. Ped green toggles 4 times in clear, then all-red, then CAR_GREEN.
- **Request during walk:** press `req_n` in PED_WALK. Expect no re-latch and CAR_GREEN persisting indefinitely afterwards. A press in PED_CLEAR is served again after 15 ticks.
- **Flash mode:** assert `flash_mode` mid-walk. Expect FLASH at the next tick, `car_yellow` toggling each tick, ped lamps dark. Deassert; expect ALLRED_2 for 1 tick, then CAR_GREEN.
- **Reset mid-phase:** pull `rst` low during CAR_YELLOW. Expect outputs at reset values in the same cycle, without waiting for a clk edge.
